axi3_slave_mem: RTL and testbench
=================================

Name: axi3_slave_mem

Overview:
- AXI3 slave (responder) RTL backed by a 64-byte byte-addressable memory.
- Sits on the far end of the AXI3 master bus used by the testbench master driver, and replaces the behavioural slave driver as a synthesizable DUT target.
- Write path (AW/W/B) and read path (AR/R) are independent state machines.
- Supports FIXED/INCR/WRAP bursts of 1–16 beats and narrow transfers via WSTRB.

Parameters:
- ID_W, 4, width of AWID/WID/BID/ARID/RID
- ADDR_W, 6, byte address width; memory size is 2**ADDR_W bytes
- DATA_W, 32, data bus width (fixed at 32; 4 byte lanes)

Ports:
- clock  in  1  single clock, all logic on posedge
- resetn  in  1  asynchronous active-low reset
- AWID  in  ID_W  write burst ID
- AWADDR  in  ADDR_W  write start byte address
- AWLEN  in  4  write beats minus 1
- AWSIZE  in  3  log2 bytes per beat
- AWBURST  in  2  00 FIXED, 01 INCR, 10 WRAP
- AWVALID  in  1  /  AWREADY  out  1
- WID  in  ID_W  /  WDATA  in  32  /  WSTRB  in  4  /  WLAST  in  1
- WVALID  in  1  /  WREADY  out  1
- BID  out  ID_W  /  BRESP  out  2  /  BVALID  out  1  /  BREADY  in  1
- ARID  in  ID_W  /  ARADDR  in  ADDR_W  /  ARLEN  in  4  /  ARSIZE  in  3  /  ARBURST  in  2
- ARVALID  in  1  /  ARREADY  out  1
- RID  out  ID_W  /  RDATA  out  32  /  RRESP  out  2  /  RLAST  out  1  /  RVALID  out  1  /  RREADY  in  1

Behaviour:
- Interface: one clock, `clock`; `resetn` is asynchronous and active-low.
- Reset:
  - All outputs are 0, both FSMs go to IDLE, and all 64 memory bytes are cleared to 0.
  - AWREADY and ARREADY rise on the first posedge after `resetn` deasserts.
- Write FSM (W_IDLE, W_DATA, W_RESP):
  - W_IDLE: AWREADY=1. On AWVALID&AWREADY, latch ID, address, length, size and burst, and clear the beat count. Next state is W_DATA, with AWREADY=0 and WREADY=1.
  - W_DATA: on each WVALID&WREADY, for each lane i with WSTRB[i]=1, mem[{addr[5:2],i}] <= WDATA[8i+7:8i]. Then advance the address and increment the beat count.
  - The beat with count==len ends the burst: WREADY=0 and next state is W_RESP. WLAST does not control the FSM.
  - W_RESP: BVALID=1, BID=latched AWID, BRESP=00. On BREADY, go to W_IDLE next cycle. BVALID is held stable until accepted.
- Read FSM (R_IDLE, R_DATA):
  - R_IDLE: ARREADY=1. On handshake, latch the AR fields and go to R_DATA.
  - On the same edge, register RDATA=word mem[addr[5:2]], with RVALID=1, RID=ARID, RRESP=00 and RLAST=(len==0).
  - R_DATA: RVALID, RDATA and RLAST are held until RREADY. On handshake, if not last, advance the address and register the next word. If last, RVALID=0 and the FSM returns to R_IDLE.
- Minimum latency:
  - Read: AR handshake to first RVALID is 1 cycle.
  - Write: last W beat to BVALID is 1 cycle.
  - Back-to-back bursts lose 1 idle cycle each.
- Address advance, with step = 1<<size:
  - FIXED: address unchanged.
  - INCR: addr + step, modulo 64 (wraps 63→0).
  - WRAP: with span = (len+1)*step, addr = (addr & ~(span-1)) | ((addr+step) & (span-1)).
  - Sizes above 2 are treated as size 2.
- Read-during-write: the read and write paths run concurrently. An RDATA word registered in the same edge as a write to that word captures the pre-write contents.
- Reset asserted mid-burst: the burst is aborted and no response is issued. Memory is cleared.

Optional Feature:
- Macro: AXI3_SLAVE_ERR_RESP_EN.
- When defined:
  - BRESP=10 (SLVERR) if any beat has WID≠AWID, or WLAST disagrees with (count==len), or AWSIZE>2. Failing beats are not written to memory.
  - RRESP=10 on every beat of a burst with ARSIZE>2 or burst type 11, with RDATA=0.
  - WRAP with len not in {1,3,7,15} gives SLVERR on both paths.
- When undefined: responses are always 00, and all such conditions are handled as in Behaviour.

Test Plan:
- Single write: AW addr=0x04, len=0, size=2, INCR; WDATA=0xDEADBEEF, WSTRB=F; BREADY=1 → BVALID 1 cycle after the W beat, BRESP=00. Then read at 0x04 → RDATA=0xDEADBEEF, RLAST=1.
- INCR 4-beat write at 0x3C, data 1,2,3,4 → words 0x3C, 0x00, 0x04, 0x08 hold 1..4 (modulo-64 wrap). A read burst with the same address and length returns 1,2,3,4 with RLAST on beat 4 only.
- WRAP len=3, size=2, addr=0x18 → beats go to 0x18, 0x1C, 0x10, 0x14. Read back in the same order.
- Partial strobe: word 0x20=0x11223344, then write 0xAABBCCDD with WSTRB=0101 → read 0x11BB33DD.
- Backpressure: RREADY low for 3 cycles on beat 2 of 4 → RDATA and RLAST stable throughout. BREADY low for 5 cycles → BVALID and BID held, AWREADY stays 0.
- With AXI3_SLAVE_ERR_RESP_EN defined, WID=5 vs AWID=3 → BRESP=10 and memory unchanged. Assert resetn mid-read burst → RVALID=0 immediately, and ARREADY=1 after release.

Source files
------------

// File: rtl/axi3_slave_mem.sv
// AXI3 responder over a 2**ADDR_W byte memory; independent AW/W/B and AR/R FSMs.
// Optional SLVERR reporting: define AXI3_SLAVE_ERR_RESP_EN.
module axi3_slave_mem #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [ID_W-1:0]   AWID,
    input  logic [ADDR_W-1:0] AWADDR,
    input  logic [3:0]        AWLEN,
    input  logic [2:0]        AWSIZE,
    input  logic [1:0]        AWBURST,
    input  logic              AWVALID,
    output logic              AWREADY,
    input  logic [ID_W-1:0]   WID,
    input  logic [DATA_W-1:0] WDATA,
    input  logic [3:0]        WSTRB,
    input  logic              WLAST,
    input  logic              WVALID,
    output logic              WREADY,
    output logic [ID_W-1:0]   BID,
    output logic [1:0]        BRESP,
    output logic              BVALID,
    input  logic              BREADY,
    input  logic [ID_W-1:0]   ARID,
    input  logic [ADDR_W-1:0] ARADDR,
    input  logic [3:0]        ARLEN,
    input  logic [2:0]        ARSIZE,
    input  logic [1:0]        ARBURST,
    input  logic              ARVALID,
    output logic              ARREADY,
    output logic [ID_W-1:0]   RID,
    output logic [DATA_W-1:0] RDATA,
    output logic [1:0]        RRESP,
    output logic              RLAST,
    output logic              RVALID,
    input  logic              RREADY
);
    localparam int MEM_N = 2**ADDR_W;
    typedef logic [ADDR_W+4:0] wide_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wst_t;
    typedef enum logic {R_IDLE, R_DATA} rst_t;

    logic [7:0] mem_q [MEM_N];

    function automatic logic [ADDR_W-1:0] next_addr(
        input logic [ADDR_W-1:0] a, input logic [3:0] len,
        input logic [2:0] size, input logic [1:0] burst);
        logic [2:0] sz;
        wide_t step, span, ax, nx;
        sz   = (size > 3'd2) ? 3'd2 : size;
        step = wide_t'(1) << sz;
        span = (wide_t'(len) + wide_t'(1)) * step;
        ax   = wide_t'(a);
        unique case (burst)
            2'b00:   nx = ax;
            2'b10:   nx = (ax & ~(span - 1)) | ((ax + step) & (span - 1));
            default: nx = ax + step;
        endcase
        return nx[ADDR_W-1:0];
    endfunction

    function automatic logic [31:0] rd_word(input logic [ADDR_W-1:0] a);
        return {mem_q[{a[ADDR_W-1:2], 2'd3}], mem_q[{a[ADDR_W-1:2], 2'd2}],
                mem_q[{a[ADDR_W-1:2], 2'd1}], mem_q[{a[ADDR_W-1:2], 2'd0}]};
    endfunction

    wst_t              w_q, w_d;
    logic              awready_q, wready_q, bvalid_q;
    logic [ID_W-1:0]   awid_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [3:0]        wlen_q, wcnt_q;
    logic [2:0]        wsize_q;
    logic [1:0]        wburst_q;
    logic              aw_hs, w_hs, b_hs, wlast_beat, wok, werr;

    rst_t              r_q, r_d;
    logic              arready_q, rvalid_q, rlast_q;
    logic [ID_W-1:0]   rid_q;
    logic [ADDR_W-1:0] raddr_q, rnext;
    logic [3:0]        rlen_q, rcnt_q;
    logic [2:0]        rsize_q;
    logic [1:0]        rburst_q, rresp_q;
    logic [DATA_W-1:0] rdata_q;
    logic              ar_hs, r_hs, ar_bad, rerr;

    assign aw_hs      = AWVALID & awready_q;
    assign w_hs       = WVALID & wready_q;
    assign b_hs       = BREADY & bvalid_q;
    assign ar_hs      = ARVALID & arready_q;
    assign r_hs       = RREADY & rvalid_q;
    assign wlast_beat = (wcnt_q == wlen_q);
    assign rnext      = next_addr(raddr_q, rlen_q, rsize_q, rburst_q);

`ifdef AXI3_SLAVE_ERR_RESP_EN
    function automatic logic len_ok(input logic [3:0] l);
        return (l == 4'd1) || (l == 4'd3) || (l == 4'd7) || (l == 4'd15);
    endfunction
    logic werr_q, rerr_q, aw_bad;
    assign aw_bad = (AWSIZE > 3'd2) || (AWBURST == 2'b10 && !len_ok(AWLEN));
    assign ar_bad = (ARSIZE > 3'd2) || (ARBURST == 2'b11)
                 || (ARBURST == 2'b10 && !len_ok(ARLEN));
    assign wok    = (WID == awid_q) && (WLAST == wlast_beat);
    assign werr   = werr_q;
    assign rerr   = rerr_q;
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            werr_q <= 1'b0;
            rerr_q <= 1'b0;
        end else begin
            if (aw_hs) werr_q <= aw_bad;
            else if (w_hs && !wok) werr_q <= 1'b1;
            if (ar_hs) rerr_q <= ar_bad;
        end
    end
`else
    logic unused_ok;
    assign unused_ok = ^{WID, WLAST};
    assign ar_bad    = 1'b0;
    assign wok       = 1'b1;
    assign werr      = 1'b0;
    assign rerr      = 1'b0;
`endif

    always_comb begin
        w_d = w_q;
        unique case (w_q)
            W_IDLE:  if (aw_hs) w_d = W_DATA;
            W_DATA:  if (w_hs && wlast_beat) w_d = W_RESP;
            W_RESP:  if (b_hs) w_d = W_IDLE;
            default: w_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_d = r_q;
        unique case (r_q)
            R_IDLE:  if (ar_hs) r_d = R_DATA;
            R_DATA:  if (r_hs && rlast_q) r_d = R_IDLE;
            default: r_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            w_q       <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            awid_q    <= '0;
            waddr_q   <= '0;
            wlen_q    <= '0;
            wcnt_q    <= '0;
            wsize_q   <= '0;
            wburst_q  <= '0;
        end else begin
            w_q       <= w_d;
            awready_q <= (w_d == W_IDLE);
            wready_q  <= (w_d == W_DATA);
            bvalid_q  <= (w_d == W_RESP);
            if (aw_hs) begin
                awid_q   <= AWID;
                waddr_q  <= AWADDR;
                wlen_q   <= AWLEN;
                wsize_q  <= AWSIZE;
                wburst_q <= AWBURST;
                wcnt_q   <= '0;
            end else if (w_hs) begin
                waddr_q <= next_addr(waddr_q, wlen_q, wsize_q, wburst_q);
                wcnt_q  <= wcnt_q + 4'd1;
            end
        end
    end

    // Non-blocking update: a same-edge read of this word sees old data.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < MEM_N; i++) mem_q[i] <= '0;
        end else if (w_hs && wok) begin
            for (int i = 0; i < 4; i++)
                if (WSTRB[i])
                    mem_q[{waddr_q[ADDR_W-1:2], 2'(i)}] <= WDATA[8*i +: 8];
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_q       <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rcnt_q    <= '0;
            rsize_q   <= '0;
            rburst_q  <= '0;
            rresp_q   <= '0;
            rdata_q   <= '0;
        end else begin
            r_q       <= r_d;
            arready_q <= (r_d == R_IDLE);
            if (ar_hs) begin
                rid_q    <= ARID;
                raddr_q  <= ARADDR;
                rlen_q   <= ARLEN;
                rsize_q  <= ARSIZE;
                rburst_q <= ARBURST;
                rcnt_q   <= '0;
                rvalid_q <= 1'b1;
                rlast_q  <= (ARLEN == 4'd0);
                rresp_q  <= {ar_bad, 1'b0};
                rdata_q  <= ar_bad ? '0 : rd_word(ARADDR);
            end else if (r_hs) begin
                if (rlast_q) begin
                    rvalid_q <= 1'b0;
                    rlast_q  <= 1'b0;
                end else begin
                    raddr_q <= rnext;
                    rcnt_q  <= rcnt_q + 4'd1;
                    rlast_q <= (rcnt_q + 4'd1 == rlen_q);
                    rdata_q <= rerr ? '0 : rd_word(rnext);
                end
            end
        end
    end

    assign AWREADY = awready_q;
    assign WREADY  = wready_q;
    assign BVALID  = bvalid_q;
    assign BID     = awid_q;
    assign BRESP   = {bvalid_q & werr, 1'b0};
    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RID     = rid_q;
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;
    assign RLAST   = rlast_q;
endmodule

// File: tb/tb_axi3_slave_mem.sv
// Scoreboard bench for axi3_slave_mem: model memory predicts every B and R beat.
module tb_axi3_slave_mem;
    logic clock = 1'b0;
    logic resetn = 1'b0;
    logic [3:0]  AWID = '0, WID = '0, ARID = '0, BID, RID;
    logic [5:0]  AWADDR = '0, ARADDR = '0;
    logic [3:0]  AWLEN = '0, ARLEN = '0, WSTRB = '0;
    logic [2:0]  AWSIZE = 3'd2, ARSIZE = 3'd2;
    logic [1:0]  AWBURST = '0, ARBURST = '0, BRESP, RRESP;
    logic        AWVALID = 0, WVALID = 0, WLAST = 0, BREADY = 0;
    logic        ARVALID = 0, RREADY = 0;
    logic        AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST;
    logic [31:0] WDATA = '0, RDATA;

    axi3_slave_mem dut (
        .clock(clock), .resetn(resetn),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
        .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
        .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
        .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] d;
        logic        last;
        logic [3:0]  id;
    } rexp_t;

    rexp_t       rq[$];
    logic [5:0]  bq[$];
    logic [7:0]  mdl [64];
    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    int n_tests = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int beat_addr(int a, int len, int burst, int i);
        int span, base;
        span = (len + 1) * 4;
        if (burst == 0) return a;
        if (burst == 2) begin
            base = a - (a % span);
            return base + ((a - base + i * 4) % span);
        end
        return (a + i * 4) % 64;
    endfunction

    function automatic logic [31:0] mdl_word(int a);
        int b;
        b = a - (a % 4);
        return {mdl[b+3], mdl[b+2], mdl[b+1], mdl[b]};
    endfunction

    task automatic wait_hi(input string tag, ref logic s);
        int n;
        n = 0;
        while (s !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk(tag, 32'(s), 32'd1);
    endtask

    task automatic do_write(input logic [3:0] id, input logic [3:0] wid,
                            input int addr, input int len, input int burst,
                            input int bstall, input logic [1:0] eresp);
        int a;
        bq.push_back({id, eresp});
        AWID = id; AWADDR = 6'(addr); AWLEN = 4'(len);
        AWBURST = 2'(burst); AWVALID = 1'b1;
        wait_hi("awready", AWREADY);
        @(negedge clock);
        AWVALID = 1'b0;
        for (int i = 0; i <= len; i++) begin
            WID = wid; WDATA = wd[i]; WSTRB = ws[i];
            WLAST = (i == len); WVALID = 1'b1;
            wait_hi("wready", WREADY);
            if (eresp == 2'b00) begin
                a = beat_addr(addr, len, burst, i);
                for (int l = 0; l < 4; l++)
                    if (ws[i][l]) mdl[a - (a % 4) + l] = wd[i][8*l +: 8];
            end
            @(negedge clock);
        end
        WVALID = 1'b0; WLAST = 1'b0;
        chk("bvalid_lat", 32'(BVALID), 32'd1);
        begin
            logic [5:0] e;
            e = bq.pop_front();
            chk("bid", 32'(BID), 32'(e[5:2]));
            chk("bresp", 32'(BRESP), 32'(e[1:0]));
            for (int k = 0; k < bstall; k++) begin
                @(negedge clock);
                chk("bvalid_hold", 32'(BVALID), 32'd1);
                chk("bid_hold", 32'(BID), 32'(e[5:2]));
                chk("awready_low", 32'(AWREADY), 32'd0);
            end
        end
        BREADY = 1'b1;
        @(negedge clock);
        BREADY = 1'b0;
        chk("bvalid_drop", 32'(BVALID), 32'd0);
        chk("awready_back", 32'(AWREADY), 32'd1);
    endtask

    task automatic ar_send(input logic [3:0] id, input int addr,
                           input int len, input int burst);
        for (int i = 0; i <= len; i++)
            rq.push_back({mdl_word(beat_addr(addr, len, burst, i)),
                          (i == len), id});
        ARID = id; ARADDR = 6'(addr); ARLEN = 4'(len);
        ARBURST = 2'(burst); ARVALID = 1'b1;
        wait_hi("arready", ARREADY);
        @(negedge clock);
        ARVALID = 1'b0;
        chk("rvalid_lat", 32'(RVALID), 32'd1);
    endtask

    task automatic do_read(input logic [3:0] id, input int addr,
                           input int len, input int burst, input int stall);
        rexp_t e;
        RREADY = 1'b1;
        ar_send(id, addr, len, burst);
        for (int i = 0; i <= len; i++) begin
            wait_hi("rvalid", RVALID);
            e = rq.pop_front();
            chk("rdata", RDATA, e.d);
            chk("rlast", 32'(RLAST), 32'(e.last));
            chk("rid", 32'(RID), 32'(e.id));
            chk("rresp", 32'(RRESP), 32'd0);
            if (i == stall) begin
                RREADY = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clock);
                    chk("rdata_hold", RDATA, e.d);
                    chk("rlast_hold", 32'(RLAST), 32'(e.last));
                    chk("rvalid_hold", 32'(RVALID), 32'd1);
                end
                RREADY = 1'b1;
            end
            @(negedge clock);
        end
        RREADY = 1'b0;
        chk("rvalid_drop", 32'(RVALID), 32'd0);
        chk("arready_back", 32'(ARREADY), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 64; i++) mdl[i] = '0;
        repeat (3) @(negedge clock);
        chk("rst_awready", 32'(AWREADY), 32'd0);
        chk("rst_arready", 32'(ARREADY), 32'd0);
        chk("rst_bvalid", 32'(BVALID), 32'd0);
        chk("rst_rvalid", 32'(RVALID), 32'd0);
        resetn = 1'b1;
        @(negedge clock);
        chk("awready_up", 32'(AWREADY), 32'd1);
        chk("arready_up", 32'(ARREADY), 32'd1);

        do_read(4'h1, 'h04, 0, 1, -1);

        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
        do_write(4'h2, 4'h2, 'h04, 0, 1, 0, 2'b00);
        do_read(4'h2, 'h04, 0, 1, -1);

        for (int i = 0; i < 4; i++) begin
            wd[i] = 32'(i + 1); ws[i] = 4'hF;
        end
        do_write(4'h3, 4'h3, 'h3C, 3, 1, 0, 2'b00);
        do_read(4'h3, 'h3C, 3, 1, -1);
        do_read(4'h4, 'h00, 0, 1, -1);

        for (int i = 0; i < 4; i++) begin
            wd[i] = 32'hA0 + 32'(i); ws[i] = 4'hF;
        end
        do_write(4'h5, 4'h5, 'h18, 3, 2, 0, 2'b00);
        do_read(4'h5, 'h18, 3, 2, -1);
        do_read(4'h6, 'h10, 3, 1, -1);

        wd[0] = 32'h11223344; ws[0] = 4'hF;
        do_write(4'h7, 4'h7, 'h20, 0, 1, 0, 2'b00);
        wd[0] = 32'hAABBCCDD; ws[0] = 4'b0101;
        do_write(4'h7, 4'h7, 'h20, 0, 1, 0, 2'b00);
        chk("strb_model", mdl_word('h20), 32'h11BB33DD);
        do_read(4'h7, 'h20, 0, 1, -1);

        wd[0] = 32'h000000C1; ws[0] = 4'b0001;
        wd[1] = 32'h0000C200; ws[1] = 4'b0010;
        wd[2] = 32'hC3000000; ws[2] = 4'b1000;
        do_write(4'h8, 4'h8, 'h30, 2, 0, 5, 2'b00);
        do_read(4'h8, 'h30, 2, 0, -1);

        do_read(4'h9, 'h3C, 3, 1, 1);

`ifdef AXI3_SLAVE_ERR_RESP_EN
        wd[0] = 32'h12345678; ws[0] = 4'hF;
        do_write(4'h3, 4'h5, 'h04, 0, 1, 0, 2'b10);
        do_read(4'h3, 'h04, 0, 1, -1);
`endif

        RREADY = 1'b1;
        ar_send(4'hA, 'h3C, 3, 1);
        chk("abort_beat0", RDATA, rq[0].d);
        @(negedge clock);
        resetn = 1'b0;
        #1;
        chk("abort_rvalid", 32'(RVALID), 32'd0);
        chk("abort_arready", 32'(ARREADY), 32'd0);
        RREADY = 1'b0;
        rq.delete();
        for (int i = 0; i < 64; i++) mdl[i] = '0;
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        chk("rel_arready", 32'(ARREADY), 32'd1);
        chk("rel_awready", 32'(AWREADY), 32'd1);
        do_read(4'hB, 'h04, 0, 1, -1);
        do_read(4'hC, 'h3C, 3, 1, -1);

        chk("rq_empty", 32'(rq.size()), 32'd0);
        chk("bq_empty", 32'(bq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
